fetch_stage: RTL and testbench

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It sits directly upstream of the static branch predictor. Each cycle it supplies the fetched instruction word and the fetch PC to the predictor. It consumes the predictor's redirect target, redirect select and mispredict flush, and it also takes jump/branch redirects resolved in Execute and stall/flush controls from the hazard unit.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Optional FETCH_STATS_EN adds saturating fetch/prediction/mispredict counters.
module fetch_stage #(
    parameter int unsigned              DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned              BOOT_CYCLES  = 2,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic [DATA_WIDTH-1:0] PCBPU,
    input  logic                  PCBPUSrc,
    input  logic                  flushBranch,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  PCSrcE,
`ifdef FETCH_STATS_EN
    output logic [31:0]           FetchCount,
    output logic [31:0]           PredCount,
    output logic [31:0]           MispredCount,
`endif
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] RDF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  PredTakenD
);

    typedef enum logic {StBoot, StRun} state_e;

    localparam logic [3:0]            BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

    state_e                state_q;
    logic [3:0]            boot_cnt_q;
    logic                  run;
    logic                  squash;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_next;

    assign run        = (state_q == StRun);
    assign squash     = flushBranch | PCSrcE | FlushD;
    assign load_valid = run & ~squash & ~StallD;
    assign pc_plus4   = PCF + PC_STEP;
    assign RDF        = run ? InstrF : NOP_INSTR;

    // Redirects outrank StallF; a predicted target only applies when not stalled.
    always_comb begin
        pc_next = PCF;
        if (!run) begin
            pc_next = RESET_VECTOR;
        end else if (flushBranch) begin
            pc_next = PCBPU & ALIGN_MASK;
        end else if (PCSrcE) begin
            pc_next = PCTargetE & ALIGN_MASK;
        end else if (StallF) begin
            pc_next = PCF;
        end else if (PCBPUSrc) begin
            pc_next = PCBPU & ALIGN_MASK;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            boot_cnt_q <= '0;
            PCF        <= RESET_VECTOR;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
            PredTakenD <= 1'b0;
        end else begin
            if (state_q == StBoot) begin
                boot_cnt_q <= boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_q <= StRun;
                end
            end
            PCF <= pc_next;
            // Bubble during boot and on any flush; flush beats StallD.
            if (!run || squash) begin
                InstrD     <= NOP_INSTR;
                PCD        <= '0;
                PCPlus4D   <= '0;
                ValidD     <= 1'b0;
                PredTakenD <= 1'b0;
            end else if (!StallD) begin
                InstrD     <= InstrF;
                PCD        <= PCF;
                PCPlus4D   <= pc_plus4;
                ValidD     <= 1'b1;
                PredTakenD <= PCBPUSrc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FetchCount   <= '0;
            PredCount    <= '0;
            MispredCount <= '0;
        end else begin
            if (load_valid && FetchCount != '1) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (load_valid && PCBPUSrc && PredCount != '1) begin
                PredCount <= PredCount + 32'd1;
            end
            if (run && flushBranch && MispredCount != '1) begin
                MispredCount <= MispredCount + 32'd1;
            end
        end
    end
`else
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan cases plus randomized
// stimulus against a cycle-count based reference model.
module tb_fetch_stage;

    localparam int unsigned BOOT_CYCLES  = 2;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] BEQ16        = 32'h0000_0863;

    logic        clk;
    logic        rst;
    logic [31:0] InstrF;
    logic        StallF, StallD, FlushD;
    logic [31:0] PCBPU;
    logic        PCBPUSrc, flushBranch;
    logic [31:0] PCTargetE;
    logic        PCSrcE;
    logic [31:0] PCF, RDF, InstrD, PCD, PCPlus4D;
    logic        ValidD, PredTakenD;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCount, PredCount, MispredCount;
`endif

    fetch_stage #(
        .DATA_WIDTH  (32),
        .RESET_VECTOR(RESET_VECTOR),
        .BOOT_CYCLES (BOOT_CYCLES),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .InstrF     (InstrF),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCBPU      (PCBPU),
        .PCBPUSrc   (PCBPUSrc),
        .flushBranch(flushBranch),
        .PCTargetE  (PCTargetE),
        .PCSrcE     (PCSrcE),
`ifdef FETCH_STATS_EN
        .FetchCount  (FetchCount),
        .PredCount   (PredCount),
        .MispredCount(MispredCount),
`endif
        .PCF        (PCF),
        .RDF        (RDF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .PredTakenD (PredTakenD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges since reset release decide boot vs run.
    int          m_cyc;
    logic [31:0] m_pc, m_instrd, m_pcd, m_pc4d;
    logic        m_vd, m_ptd;
    logic [31:0] m_fetch, m_pred, m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_pc    = RESET_VECTOR;
        m_instrd = NOP;
        m_pcd   = 0;
        m_pc4d  = 0;
        m_vd    = 0;
        m_ptd   = 0;
        m_fetch = 0;
        m_pred  = 0;
        m_mis   = 0;
    endtask

    task automatic compare_all();
        check("PCF", PCF, m_pc);
        check("InstrD", InstrD, m_instrd);
        check("PCD", PCD, m_pcd);
        check("PCPlus4D", PCPlus4D, m_pc4d);
        check("ValidD", {31'b0, ValidD}, {31'b0, m_vd});
        check("PredTakenD", {31'b0, PredTakenD}, {31'b0, m_ptd});
`ifdef FETCH_STATS_EN
        check("FetchCount", FetchCount, m_fetch);
        check("PredCount", PredCount, m_pred);
        check("MispredCount", MispredCount, m_mis);
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_PCF", PCF, RESET_VECTOR);
        check("rst_ValidD", {31'b0, ValidD}, 32'd0);
        compare_all();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic drive_cycle(input logic [31:0] instr, input logic stf, input logic std,
                               input logic fld, input logic [31:0] bpu, input logic bpusrc,
                               input logic flb, input logic [31:0] tgt, input logic srce);
        logic        run;
        logic [31:0] pc_n;
        InstrF = instr; StallF = stf; StallD = std; FlushD = fld;
        PCBPU = bpu; PCBPUSrc = bpusrc; flushBranch = flb; PCTargetE = tgt; PCSrcE = srce;
        #1;
        run = (m_cyc >= int'(BOOT_CYCLES));
        check("RDF", RDF, run ? instr : NOP);
        if (!run) begin
            pc_n = RESET_VECTOR;
        end else if (flb) begin
            pc_n = {bpu[31:2], 2'b00};
        end else if (srce) begin
            pc_n = {tgt[31:2], 2'b00};
        end else if (stf) begin
            pc_n = m_pc;
        end else if (bpusrc) begin
            pc_n = {bpu[31:2], 2'b00};
        end else begin
            pc_n = m_pc + 32'd4;
        end
        if (!run || flb || srce || fld) begin
            m_instrd = NOP; m_pcd = 0; m_pc4d = 0; m_vd = 0; m_ptd = 0;
        end else if (!std) begin
            m_instrd = instr; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_vd = 1; m_ptd = bpusrc;
            m_fetch++;
            if (bpusrc) m_pred++;
        end
        if (run && flb) m_mis++;
        m_pc = pc_n;
        m_cyc++;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle($urandom, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        end
    endtask

    task automatic jump(input logic [31:0] tgt);
        drive_cycle($urandom, 0, 0, 0, 32'h0, 0, 0, tgt, 1);
    endtask

    initial begin
        rst = 1'b0;
        InstrF = 0; StallF = 0; StallD = 0; FlushD = 0;
        PCBPU = 0; PCBPUSrc = 0; flushBranch = 0; PCTargetE = 0; PCSrcE = 0;
        model_reset();
        #2;
        apply_reset();

        // Boot then sequential fetch.
        idle(2);
        check("boot_PCF", PCF, 32'h0);
        check("boot_ValidD", {31'b0, ValidD}, 32'd0);
        idle(1);
        check("first_PCF", PCF, 32'h4);
        check("first_ValidD", {31'b0, ValidD}, 32'd1);
        check("first_PCD", PCD, 32'h0);
        idle(1);
        check("seq_PCF", PCF, 32'h8);

        // Predicted-taken branch.
        jump(32'h20);
        drive_cycle(BEQ16, 0, 0, 0, 32'h30, 1, 0, 32'h0, 0);
        check("taken_PCF", PCF, 32'h30);
        check("taken_PredTakenD", {31'b0, PredTakenD}, 32'd1);
        check("taken_PCD", PCD, 32'h20);

        // Mispredict overrides StallF.
        drive_cycle($urandom, 1, 0, 0, 32'h24, 0, 1, 32'h0, 0);
        check("mis_PCF", PCF, 32'h24);
        check("mis_InstrD", InstrD, NOP);
        check("mis_ValidD", {31'b0, ValidD}, 32'd0);

        // Execute redirect beats predictor target.
        drive_cycle($urandom, 0, 0, 0, 32'h30, 1, 0, 32'h100, 1);
        check("exe_PCF", PCF, 32'h100);
        check("exe_ValidD", {31'b0, ValidD}, 32'd0);

        // Stall both stages at 0x40, then release.
        jump(32'h40);
        for (int i = 0; i < 3; i++) begin
            drive_cycle($urandom, 1, 1, 0, 32'h0, 0, 0, 32'h0, 0);
            check("stall_PCF", PCF, 32'h40);
            check("stall_PCD", PCD, 32'h0);
        end
        idle(1);
        check("release_PCF", PCF, 32'h44);

        // Unaligned target masking and PC wrap.
        jump(32'hFFFF_FFFF);
        check("wrap_pre_PCF", PCF, 32'hFFFF_FFFC);
        idle(1);
        check("wrap_PCF", PCF, 32'h0);

        // Asynchronous reset mid-cycle.
        #3;
        apply_reset();

        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom, ($urandom_range(4) == 0), ($urandom_range(4) == 0),
                        ($urandom_range(9) == 0), $urandom, ($urandom_range(3) == 0),
                        ($urandom_range(9) == 0), $urandom, ($urandom_range(9) == 0));
            if (i == 300) begin
                #3;
                apply_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
